// File: rtl/whack_score_tracker.sv
// whack_score_tracker: clocked score keeper for the whack-a-mole game.
// It edge-detects the per-hole whack levels and the start level. It scores hits
// with a combo multiplier, subtracts a penalty for each miss, saturates the score
// at the top and floors it at zero. It runs the IDLE/PLAY/DONE session machine
// and keeps the best final score since reset.
// Optional build macro: SCORE_BCD_EN adds score_bcd/bcd_valid, which come from
// a sequential double-dabble converter that feeds the 7-segment driver.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset; waiting for a start rising edge
// PLAY   | game running; hits/misses update score, streak and multiplier
// DONE   | game ended; score and high_score held until the next start edge
module whack_score_tracker #(
   parameter int N_HOLES   = 9,
   parameter int SCORE_W   = 16,
   parameter int HIT_PTS   = 1,
   parameter int MISS_PTS  = 1,
   parameter int COMBO_LEN = 4,
   parameter int MAX_MULT  = 4,
   localparam int MULT_W   = $clog2(MAX_MULT + 1)
`ifdef SCORE_BCD_EN
   ,
   localparam int BCD_DIGITS = (SCORE_W * 302 + 1999) / 1000
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               game_over,
   input  logic [N_HOLES-1:0] whack,
   input  logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic [MULT_W-1:0]  mult,
   output logic               playing,
   output logic               new_high
`ifdef SCORE_BCD_EN
   ,
   output logic [4*BCD_DIGITS-1:0] score_bcd,
   output logic                    bcd_valid
`endif
);

   localparam int HITS_W     = $clog2(N_HOLES + 1);
   localparam int GAIN_MAX   = N_HOLES * HIT_PTS * MAX_MULT;
   localparam int CALC_W     = SCORE_W + $clog2(GAIN_MAX + 1) + 1;
   localparam int STREAK_MAX = COMBO_LEN * (MAX_MULT - 1);
   localparam int STREAK_W   = $clog2(STREAK_MAX + N_HOLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SCORE_W-1:0]   high_q;
   logic [MULT_W-1:0]    mult_q, mult_d;
   logic [STREAK_W-1:0]  streak_q, streak_d;
   logic                 playing_q;
   logic                 new_high_q;
   logic [N_HOLES-1:0]   whack_q;
   logic                 start_q;
   // Stays low for the first cycle after reset, so a start level that is
   // already high when reset releases does not count as a rising edge.
   logic                 start_armed_q;

   logic [N_HOLES-1:0]   whack_rise;
   logic [HITS_W-1:0]    hits;
   logic                 start_rise;
   logic [CALC_W-1:0]    calc;
   logic [STREAK_W-1:0]  streak_sum;
   logic [STREAK_W-1:0]  streak_step;

   // Edge detection and hit count for this cycle.
   always_comb begin
      whack_rise = whack & ~whack_q;
      start_rise = start & ~start_q & start_armed_q;
      hits       = '0;
      for (int i = 0; i < N_HOLES; i++) begin
         hits = hits + HITS_W'(whack_rise[i]);
      end
   end

   // Next score: it is a two's-complement sum in a wide word, then clamped to
   // the range [0, 2^SCORE_W-1]. The MSB set means the sum went negative.
   always_comb begin
      calc = CALC_W'(score_q)
           + CALC_W'(hits) * CALC_W'(HIT_PTS) * CALC_W'(mult_q)
           - (miss ? CALC_W'(MISS_PTS) : '0);
      if (calc[CALC_W-1]) begin
         score_d = '0;
      end else if (|calc[CALC_W-2:SCORE_W]) begin
         score_d = '1;
      end else begin
         score_d = calc[SCORE_W-1:0];
      end
   end

   // Next streak and multiplier. A miss resets both; hits in the same cycle
   // have already been scored at the old multiplier above.
   always_comb begin
      streak_sum = streak_q + STREAK_W'(hits);
      if (miss) begin
         streak_d = '0;
      end else if (streak_sum > STREAK_W'(STREAK_MAX)) begin
         streak_d = STREAK_W'(STREAK_MAX);
      end else begin
         streak_d = streak_sum;
      end
      streak_step = streak_d / STREAK_W'(COMBO_LEN);
      if (streak_step >= STREAK_W'(MAX_MULT - 1)) begin
         mult_d = MULT_W'(MAX_MULT);
      end else begin
         mult_d = MULT_W'(streak_step) + MULT_W'(1);
      end
   end

   // Session FSM with registered score, multiplier and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         score_q       <= '0;
         high_q        <= '0;
         mult_q        <= MULT_W'(1);
         streak_q      <= '0;
         playing_q     <= 1'b0;
         new_high_q    <= 1'b0;
         whack_q       <= '0;
         start_q       <= 1'b0;
         start_armed_q <= 1'b0;
      end else begin
         whack_q       <= whack;
         start_q       <= start;
         start_armed_q <= 1'b1;
         new_high_q    <= 1'b0;
         case (state_q)
            S_PLAY: begin
               if (game_over) begin
                  state_q   <= S_DONE;
                  playing_q <= 1'b0;
                  if (score_q > high_q) begin
                     high_q     <= score_q;
                     new_high_q <= 1'b1;
                  end
               end else begin
                  score_q  <= score_d;
                  streak_q <= streak_d;
                  mult_q   <= mult_d;
               end
            end
            default: begin
               if (start_rise) begin
                  state_q   <= S_PLAY;
                  playing_q <= 1'b1;
                  score_q   <= '0;
                  streak_q  <= '0;
                  mult_q    <= MULT_W'(1);
               end
            end
         endcase
      end
   end

   assign score      = score_q;
   assign high_score = high_q;
   assign mult       = mult_q;
   assign playing    = playing_q;
   assign new_high   = new_high_q;

`ifdef SCORE_BCD_EN
   localparam int BCD_W = 4 * BCD_DIGITS;
   localparam int CNT_W = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0] src_q;
   logic [SCORE_W-1:0] sh_q, sh_nx;
   logic [BCD_W-1:0]   acc_q, acc_adj, acc_nx;
   logic [BCD_W-1:0]   bcd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;

   // One double-dabble step: add 3 to each digit that is >= 5, then shift left.
   always_comb begin
      acc_adj = acc_q;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (acc_adj[4*d +: 4] >= 4'd5) begin
            acc_adj[4*d +: 4] = acc_adj[4*d +: 4] + 4'd3;
         end
      end
      {acc_nx, sh_nx} = {acc_adj[BCD_W-2:0], sh_q, 1'b0};
   end

   // Converter sequencing. Any change of score restarts the conversion, and a
   // down-counter counts the SCORE_W shift steps. The visible value is only
   // updated when a conversion completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q  <= '0;
         sh_q   <= '0;
         acc_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (score_q != src_q) begin
         src_q  <= score_q;
         sh_q   <= score_q;
         acc_q  <= '0;
         cnt_q  <= CNT_W'(SCORE_W);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         sh_q  <= sh_nx;
         acc_q <= acc_nx;
         cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            bcd_q  <= acc_nx;
            busy_q <= 1'b0;
         end
      end
   end

   assign score_bcd = bcd_q;
   assign bcd_valid = !busy_q && (src_q == score_q);
`endif

endmodule

// File: tb/tb_whack_score_tracker.sv
// Bench for whack_score_tracker. Two instances share the stimulus: the default
// build (16-bit score) and a 4-bit score build that exercises saturation.
// A session-level reference model predicts both.
module tb_whack_score_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        game_over;
   logic [8:0]  whack;
   logic        miss;

   logic [15:0] score0, high0;
   logic [3:0]  score1, high1;
   logic [2:0]  mult0, mult1;
   logic        play0, play1, nh0, nh1;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   int         m_score [2];
   int         m_high  [2];
   bit         m_nh    [2];
   int         m_cap   [2] = '{65535, 15};
   int         m_streak;
   bit         m_play;
   logic [8:0] m_pw;
   bit         m_ps;

   always #5 clk = ~clk;

   whack_score_tracker dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .game_over(game_over),
      .whack(whack), .miss(miss), .score(score0), .high_score(high0),
      .mult(mult0), .playing(play0), .new_high(nh0)
   );

   whack_score_tracker #(.SCORE_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .game_over(game_over),
      .whack(whack), .miss(miss), .score(score1), .high_score(high1),
      .mult(mult1), .playing(play1), .new_high(nh1)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int mult_of(input int streak);
      int m;
      m = 1 + streak / 4;
      return (m > 4) ? 4 : m;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_score[k] = 0;
         m_high[k]  = 0;
         m_nh[k]    = 0;
      end
      m_streak = 0;
      m_play   = 0;
      m_pw     = '0;
      m_ps     = 1'b1;  // start must be seen low before an edge can count
   endfunction

   function automatic void model_step(input bit st, input bit go,
                                      input logic [8:0] wh, input bit ms);
      int hits, m, s;
      bit se;
      hits = $countones(wh & ~m_pw);
      se   = st && !m_ps;
      for (int k = 0; k < 2; k++) m_nh[k] = 0;
      if (!m_play) begin
         if (se) begin
            m_play   = 1;
            m_streak = 0;
            for (int k = 0; k < 2; k++) m_score[k] = 0;
         end
      end else if (go) begin
         m_play = 0;
         for (int k = 0; k < 2; k++) begin
            if (m_score[k] > m_high[k]) begin
               m_high[k] = m_score[k];
               m_nh[k]   = 1;
            end
         end
      end else begin
         m = mult_of(m_streak);
         for (int k = 0; k < 2; k++) begin
            s = m_score[k] + hits * m - (ms ? 1 : 0);
            if (s < 0) s = 0;
            if (s > m_cap[k]) s = m_cap[k];
            m_score[k] = s;
         end
         if (ms) m_streak = 0;
         else    m_streak = (m_streak + hits > 12) ? 12 : m_streak + hits;
      end
      m_pw = wh;
      m_ps = st;
   endfunction

   task automatic check_all();
      check_eq("score",      int'(score0), m_score[0]);
      check_eq("high",       int'(high0),  m_high[0]);
      check_eq("mult",       int'(mult0),  mult_of(m_streak));
      check_eq("playing",    int'(play0),  int'(m_play));
      check_eq("new_high",   int'(nh0),    int'(m_nh[0]));
      check_eq("score_w4",   int'(score1), m_score[1]);
      check_eq("high_w4",    int'(high1),  m_high[1]);
      check_eq("mult_w4",    int'(mult1),  mult_of(m_streak));
      check_eq("playing_w4", int'(play1),  int'(m_play));
      check_eq("new_high_w4",int'(nh1),    int'(m_nh[1]));
   endtask

   // Drive one cycle of inputs (called just after a negedge), then check the
   // registered result at the following negedge.
   task automatic cyc(input bit st, input bit go, input logic [8:0] wh, input bit ms);
      start     = st;
      game_over = go;
      whack     = wh;
      miss      = ms;
      model_step(st, go, wh, ms);
      @(negedge clk);
      check_all();
   endtask

   // n single hits on hole 0, each as a rise then a fall
   task automatic single_hits(input int n, input bit st);
      for (int i = 0; i < n; i++) begin
         cyc(st, 1'b0, 9'h001, 1'b0);
         cyc(st, 1'b0, 9'h000, 1'b0);
      end
   endtask

   initial begin
      logic [8:0] wr;
      bit sr;
      rst_n = 1'b0; start = 1'b1; game_over = 1'b0; whack = '0; miss = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // start held high out of reset, whacks/misses/game_over while idle
      for (int i = 0; i < 6; i++) cyc(1'b1, i == 3, 9'(i * 37), i[0]);
      cyc(1'b0, 1'b0, 9'h000, 1'b0);

      // start, 3 hits, then 4 misses (floor at 0)
      cyc(1'b1, 1'b0, 9'h000, 1'b0);
      single_hits(3, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 9'h000, 1'b1);
      cyc(1'b0, 1'b0, 9'h000, 1'b0);

      // combo run of 9 hits then a miss
      single_hits(9, 1'b0);
      cyc(1'b0, 1'b0, 9'h000, 1'b1);

      // three holes rising together, hit + miss in one cycle, held whack
      cyc(1'b0, 1'b0, 9'h007, 1'b0);
      cyc(1'b0, 1'b0, 9'h000, 1'b0);
      cyc(1'b0, 1'b0, 9'h010, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 9'h100, 1'b0);
      cyc(1'b0, 1'b0, 9'h000, 1'b0);

      // saturate the 4-bit instance, end the game with hits in that cycle
      single_hits(20, 1'b0);
      cyc(1'b0, 1'b1, 9'h0F0, 1'b0);
      cyc(1'b0, 1'b0, 9'h00F, 1'b0);
      cyc(1'b0, 1'b1, 9'h000, 1'b1);

      // second game ends low: no new high
      cyc(1'b1, 1'b0, 9'h000, 1'b0);
      single_hits(5, 1'b1);
      cyc(1'b1, 1'b1, 9'h000, 1'b0);
      cyc(1'b0, 1'b0, 9'h000, 1'b0);

      // randomised play
      wr = '0;
      sr = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < 9; b++) begin
            if ($urandom_range(0, 5) == 0) wr[b] = ~wr[b];
         end
         if ($urandom_range(0, 15) == 0) sr = ~sr;
         cyc(sr, $urandom_range(0, 60) == 0, wr, $urandom_range(0, 7) == 0);
      end

      // asynchronous reset in the middle of a game
      cyc(1'b0, 1'b0, 9'h000, 1'b0);
      cyc(1'b1, 1'b0, 9'h000, 1'b0);
      single_hits(6, 1'b1);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 9'h001, 1'b0);
      cyc(1'b0, 1'b0, 9'h000, 1'b0);
      cyc(1'b1, 1'b0, 9'h000, 1'b0);
      single_hits(2, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
